// File: rtl/display_scanner.sv
// Scans 44 display slots through a registered responder and emits an update for any slot that changed or was marked dirty.
// Latency: 3 cycles per unchanged slot; a changed slot adds an EMIT cycle that holds until upd_ready.
// Backpressure: upd_valid and its payload stay stable until upd_ready; the keypad path never stalls.
module display_scanner (
    input  logic        clk,
    input  logic        resetn,
    output logic [5:0]  display_number,
    input  logic        display_valid,
    input  logic [39:0] display_name,
    input  logic [31:0] display_value,
    input  logic        refresh,
    output logic        upd_valid,
    input  logic        upd_ready,
    output logic [5:0]  upd_index,
    output logic        upd_blank,
    output logic [39:0] upd_name,
    output logic [31:0] upd_value,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic        input_valid,
    output logic [31:0] input_value,
    output logic [31:0] entry_buf
);
    localparam int NSLOT = 44;

    typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_CAPTURE, S_EMIT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  rst_sync;
    logic        rst_n;
    logic [5:0]  idx;
    logic [5:0]  slot;
    logic [5:0]  idx_next;
    logic [NSLOT-1:0] dirty;
    logic        cache_vld   [0:NSLOT-1];
    logic [39:0] cache_name  [0:NSLOT-1];
    logic [31:0] cache_value [0:NSLOT-1];
    logic        changed;
    logic        take_emit;
    logic        advance;
    logic        handshake;

    // Asynchronous assert, release aligned to clk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign slot      = idx - 6'd1;
    assign idx_next  = (idx == 6'(NSLOT)) ? 6'd1 : idx + 6'd1;
    assign handshake = upd_valid && upd_ready;

    // Two invalid slots compare equal regardless of name/value contents.
    assign changed = (display_valid != cache_vld[slot]) ||
                     (display_valid && ((display_name  != cache_name[slot]) ||
                                        (display_value != cache_value[slot])));

    always_comb begin
        state_d   = state_q;
        take_emit = 1'b0;
        advance   = 1'b0;
        case (state_q)
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT:    state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (changed || dirty[slot]) begin
                    take_emit = 1'b1;
                    state_d   = S_EMIT;
                end else begin
                    advance = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_EMIT: begin
                if (handshake) begin
                    advance = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            default:   state_d = S_ISSUE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_ISSUE;
            idx            <= 6'd1;
            display_number <= 6'd0;
            upd_valid      <= 1'b0;
            upd_index      <= 6'd0;
            upd_blank      <= 1'b0;
            upd_name       <= 40'd0;
            upd_value      <= 32'd0;
            dirty          <= '1;
        end else begin
            state_q <= state_d;
            if (state_q == S_ISSUE) display_number <= idx;
            if (advance) idx <= idx_next;
            if (take_emit) begin
                upd_valid <= 1'b1;
                upd_index <= idx;
                upd_blank <= !display_valid;
                upd_name  <= display_valid ? display_name  : 40'd0;
                upd_value <= display_valid ? display_value : 32'd0;
            end
            if (handshake) begin
                upd_valid   <= 1'b0;
                dirty[slot] <= 1'b0;
            end
            // Placed last so a coincident refresh overrides the dirty clear.
            if (refresh) dirty <= '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOT; i++) begin
                cache_vld[i]   <= 1'b0;
                cache_name[i]  <= 40'd0;
                cache_value[i] <= 32'd0;
            end
        end else if (handshake) begin
            cache_vld[slot]   <= !upd_blank;
            cache_name[slot]  <= upd_name;
            cache_value[slot] <= upd_value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            input_valid <= 1'b0;
            input_value <= 32'd0;
            entry_buf   <= 32'd0;
        end else begin
            input_valid <= 1'b0;
            if (key_valid) begin
                if (!key_code[4]) begin
                    entry_buf <= {entry_buf[27:0], key_code[3:0]};
                end else begin
                    case (key_code)
                        5'h10: begin
                            input_value <= entry_buf;
                            input_valid <= 1'b1;
                            entry_buf   <= 32'd0;
                        end
                        5'h11:   entry_buf <= 32'd0;
                        5'h12:   entry_buf <= entry_buf >> 4;
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: registered responder model, index-matched update scoreboard, table-driven keypad vectors.
module tb_display_scanner;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [5:0]  display_number;
    logic        display_valid = 1'b0;
    logic [39:0] display_name = 40'd0;
    logic [31:0] display_value = 32'd0;
    logic        refresh = 1'b0;
    logic        upd_valid;
    logic        upd_ready = 1'b0;
    logic [5:0]  upd_index;
    logic        upd_blank;
    logic [39:0] upd_name;
    logic [31:0] upd_value;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code = 5'd0;
    logic        input_valid;
    logic [31:0] input_value;
    logic [31:0] entry_buf;

    always #5 clk = ~clk;

    display_scanner dut (
        .clk(clk), .resetn(resetn),
        .display_number(display_number), .display_valid(display_valid),
        .display_name(display_name), .display_value(display_value),
        .refresh(refresh),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
        .upd_blank(upd_blank), .upd_name(upd_name), .upd_value(upd_value),
        .key_valid(key_valid), .key_code(key_code),
        .input_valid(input_valid), .input_value(input_value), .entry_buf(entry_buf)
    );

    typedef struct {
        logic [5:0]  index;
        logic        blank;
        logic [39:0] name;
        logic [31:0] value;
    } upd_t;

    typedef struct {
        logic        kv;
        logic [4:0]  code;
        logic [31:0] exp_buf;
        logic        exp_iv;
        logic [31:0] exp_ival;
    } kvec_t;

    upd_t        exp_q[$];
    kvec_t       ktab[$];
    logic        m_valid [1:44];
    logic [39:0] m_name  [1:44];
    logic [31:0] m_value [1:44];

    int checks = 0;
    int passes = 0;
    int vld_cycles = 0;
    int wrap_cnt = 0;
    int bad_dn = 0;
    bit dn_win = 1'b0;
    logic [5:0] dn_prev = 6'd0;

    // Registered responder: answers one clock after seeing display_number.
    always @(posedge clk) begin
        if (display_number >= 6'd1 && display_number <= 6'd44 && m_valid[display_number]) begin
            display_valid <= 1'b1;
            display_name  <= m_name[display_number];
            display_value <= m_value[display_number];
        end else begin
            display_valid <= 1'b0;
            display_name  <= 40'd0;
            display_value <= 32'd0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic push_slot(input int i);
        upd_t u;
        u.index = 6'(i);
        u.blank = !m_valid[i];
        u.name  = m_valid[i] ? m_name[i]  : 40'd0;
        u.value = m_valid[i] ? m_value[i] : 32'd0;
        exp_q.push_back(u);
    endtask

    task automatic push_all();
        for (int i = 1; i <= 44; i++) push_slot(i);
    endtask

    task automatic wait_empty(input string nm, input int bound, output int cyc);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < bound) begin
            step();
            cyc++;
        end
        check(nm, 96'(exp_q.size()), 96'd0);
    endtask

    task automatic wait_vld(input string nm, input int bound);
        int cyc;
        cyc = 0;
        while (!upd_valid && cyc < bound) begin
            step();
            cyc++;
        end
        check(nm, 96'(upd_valid), 96'd1);
    endtask

    task automatic monitor();
        int k;
        forever begin
            @(negedge clk);
            if (resetn && upd_valid) vld_cycles++;
            if (dn_win) begin
                if (dn_prev == 6'd44 && display_number == 6'd1) wrap_cnt++;
                if (display_number == 6'd0 || display_number > 6'd44) bad_dn++;
            end
            dn_prev = display_number;
            if (resetn && upd_valid && upd_ready) begin
                k = -1;
                foreach (exp_q[i]) if (k < 0 && exp_q[i].index == upd_index) k = i;
                if (k < 0) begin
                    checks++;
                    $display("FAIL unexpected_update: got index %0d, none expected", upd_index);
                end else begin
                    check($sformatf("update_slot_%0d", upd_index),
                          96'({upd_blank, upd_name, upd_value}),
                          96'({exp_q[k].blank, exp_q[k].name, exp_q[k].value}));
                    exp_q.delete(k);
                end
            end
        end
    endtask

    task automatic kadd(input logic kv, input logic [4:0] code, input logic [31:0] eb,
                        input logic eiv, input logic [31:0] eival);
        kvec_t v;
        v.kv = kv; v.code = code; v.exp_buf = eb; v.exp_iv = eiv; v.exp_ival = eival;
        ktab.push_back(v);
    endtask

    task automatic run_keypad();
        foreach (ktab[i]) begin
            key_valid = ktab[i].kv;
            key_code  = ktab[i].code;
            step();
            key_valid = 1'b0;
            check($sformatf("key_vec_%0d", i),
                  96'({entry_buf, input_valid, input_value}),
                  96'({ktab[i].exp_buf, ktab[i].exp_iv, ktab[i].exp_ival}));
            step();
            if (ktab[i].exp_iv) check($sformatf("key_pulse_end_%0d", i), 96'(input_valid), 96'd0);
        end
    endtask

    initial begin
        int cyc;
        int v0;
        for (int i = 1; i <= 44; i++) begin
            m_valid[i] = 1'b0; m_name[i] = 40'd0; m_value[i] = 32'd0;
        end
        m_valid[1] = 1'b1; m_name[1] = "ADD_1"; m_value[1] = 32'd5;
        m_valid[2] = 1'b1; m_name[2] = "ADD_2"; m_value[2] = 32'd7;
        m_valid[3] = 1'b1; m_name[3] = "RESUL"; m_value[3] = 32'd12;

        kadd(1, 5'h01, 32'h1,        0, 32'h0);
        kadd(1, 5'h02, 32'h12,       0, 32'h0);
        kadd(1, 5'h03, 32'h123,      0, 32'h0);
        kadd(1, 5'h12, 32'h12,       0, 32'h0);
        kadd(1, 5'h0A, 32'h12A,      0, 32'h0);
        kadd(1, 5'h10, 32'h0,        1, 32'h12A);
        kadd(1, 5'h05, 32'h5,        0, 32'h12A);
        kadd(1, 5'h11, 32'h0,        0, 32'h12A);
        kadd(1, 5'h07, 32'h7,        0, 32'h12A);
        kadd(1, 5'h15, 32'h7,        0, 32'h12A);
        kadd(0, 5'h03, 32'h7,        0, 32'h12A);
        kadd(1, 5'h1F, 32'h7,        0, 32'h12A);
        kadd(1, 5'h11, 32'h0,        0, 32'h12A);
        kadd(1, 5'h01, 32'h1,        0, 32'h12A);
        kadd(1, 5'h02, 32'h12,       0, 32'h12A);
        kadd(1, 5'h03, 32'h123,      0, 32'h12A);
        kadd(1, 5'h04, 32'h1234,     0, 32'h12A);
        kadd(1, 5'h05, 32'h12345,    0, 32'h12A);
        kadd(1, 5'h06, 32'h123456,   0, 32'h12A);
        kadd(1, 5'h07, 32'h1234567,  0, 32'h12A);
        kadd(1, 5'h08, 32'h12345678, 0, 32'h12A);
        kadd(1, 5'h09, 32'h23456789, 0, 32'h12A);
        kadd(1, 5'h00, 32'h34567890, 0, 32'h12A);
        kadd(1, 5'h10, 32'h0,        1, 32'h34567890);
        kadd(1, 5'h12, 32'h0,        0, 32'h34567890);

        fork monitor(); join_none

        repeat (3) step();
        check("rst_display_number", 96'(display_number), 96'd0);
        check("rst_upd_valid", 96'(upd_valid), 96'd0);
        check("rst_upd_payload", 96'({upd_index, upd_blank, upd_name, upd_value}), 96'd0);
        check("rst_input", 96'({input_valid, input_value}), 96'd0);
        check("rst_entry_buf", 96'(entry_buf), 96'd0);

        upd_ready = 1'b1;
        push_all();
        resetn = 1'b1;
        wait_empty("first_pass", 400, cyc);

        v0 = vld_cycles; wrap_cnt = 0; bad_dn = 0; dn_win = 1'b1;
        repeat (140) step();
        dn_win = 1'b0;
        check("quiet_no_update", 96'(vld_cycles - v0), 96'd0);
        check("dn_wrap_seen", 96'(wrap_cnt >= 1), 96'd1);
        check("dn_in_range", 96'(bad_dn), 96'd0);

        m_value[2] = 32'd9;
        push_slot(2);
        wait_empty("slot2_update", 300, cyc);
        check("slot2_latency", 96'(cyc <= 136), 96'd1);
        v0 = vld_cycles;
        repeat (140) step();
        check("slot2_single_update", 96'(vld_cycles - v0), 96'd0);

        upd_ready = 1'b0;
        m_value[3] = 32'd13;
        push_slot(3);
        wait_vld("hold_vld_rise", 300);
        m_value[3] = 32'd99;
        for (int i = 0; i < 20; i++) begin
            step();
            check("hold_stable", 96'({upd_valid, upd_index, upd_value, display_number}),
                  96'({1'b1, 6'd3, 32'd13, 6'd3}));
        end
        upd_ready = 1'b1;
        wait_empty("hold_release", 20, cyc);
        push_slot(3);
        wait_empty("slot3_next_pass", 300, cyc);

        repeat (17) step();
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        push_all();
        fork
            wait_empty("refresh_pass", 600, cyc);
            run_keypad();
        join

        upd_ready = 1'b0;
        m_value[1] = 32'd6;
        push_slot(1);
        wait_vld("emit_before_reset", 300);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_drops_upd", 96'({upd_valid, display_number}), 96'd0);
        exp_q.delete();
        repeat (2) step();
        push_all();
        upd_ready = 1'b1;
        resetn = 1'b1;
        wait_empty("post_reset_pass", 400, cyc);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
